axi_emif_freeze_drain_ctrl: RTL and testbench
=============================================

// Module: axi_emif_freeze_drain_ctrl
// PURPOSE
//  Sits between the user-side AXI-MM pipeline register and the EMIF AXI-MM port and gates only the valid/ready handshakes; payloads bypass the block.
//  On freeze request: stops new AW/AR/W traffic without breaking AXI valid/ready rules, lets in-flight bursts and
//  responses complete, then acknowledges. Used for partial-reconfiguration freeze and port reset.
// PARAMETERS
//  MAX_OUTSTANDING  64                          max outstanding writes (AW w/o B) and reads (AR w/o last R), each
//  CNT_W            $clog2(MAX_OUTSTANDING+1)   counter width (derived)
//  TIMEOUT_CYC      4096                        drain timeout in clk cycles (used only with AXI_EMIF_DRAIN_TIMEOUT_EN)
// PORTS
//  clk            in   1  EMIF user clock
//  rst_n          in   1  asynchronous active-low reset
//  freeze_req     in   1  level; 1 = drain and hold the port frozen
//  freeze_ack     out  1  1 = frozen; no transaction outstanding
//  drain_timeout  out  1  sticky; drain ended by timeout (0 when macro off)
//  u_awvalid/u_awready  in/out  1  upstream AW handshake
//  u_wvalid/u_wready    in/out  1  upstream W handshake
//  u_wlast              in      1  upstream W last beat
//  u_arvalid/u_arready  in/out  1  upstream AR handshake
//  d_awvalid/d_awready  out/in  1  EMIF-side AW handshake
//  d_wvalid/d_wready    out/in  1  EMIF-side W handshake
//  d_arvalid/d_arready  out/in  1  EMIF-side AR handshake
//  d_bvalid, d_bready   in      1  EMIF B handshake, monitored only
//  d_rvalid, d_rready, d_rlast  in  1  EMIF R handshake, monitored only
// BEHAVIOUR
//  - Pass-through: d_xvalid = u_xvalid & ~gate_x; u_xready = d_xready & ~gate_x. Combinational, zero latency.
//  - Counters:
//    - wr_out: +1 on AW handshake, -1 on B handshake.
//    - rd_out: +1 on AR handshake, -1 on R handshake with rlast.
//    - w_pend: +1 on AW handshake, -1 on W handshake with wlast; signed, to allow W-before-AW.
//    - Simultaneous +1/-1 on the same counter leaves it unchanged.
//  - Saturation: gate_aw is forced on when wr_out == MAX_OUTSTANDING; gate_ar likewise for rd_out. Counters never wrap.
//  - Hold flags: aw_hold <= d_awvalid & ~d_awready; same scheme for ar_hold and w_hold.
//    - A gate may only rise while its hold flag = 0, so a valid already presented is never withdrawn.
//  - w_inburst: set on a W handshake without wlast, cleared on a W handshake with wlast.
//  - FSM (reset state RUN):
//    - RUN: gates off except saturation. freeze_req=1 -> DRAIN.
//    - DRAIN:
//      - gate_aw = ~aw_hold; gate_ar = ~ar_hold.
//      - gate_w = ~w_hold & ~w_inburst & (w_pend <= 0).
//      - freeze_req=0 -> RUN (abort drain).
//      - wr_out==0 & rd_out==0 & w_pend==0 & ~w_inburst & no hold -> FROZEN.
//    - FROZEN: all gates on; freeze_ack=1. freeze_req=0 -> RUN.
//  - freeze_ack is registered: rises the cycle after FROZEN is entered and falls the cycle after leaving it.
//  - Reset values: freeze_ack=0, drain_timeout=0, all counters 0, all hold flags 0, state RUN.
//    - Outputs reflect the inputs combinationally once reset is released.
//  - Reset asserted mid-operation: all state clears asynchronously. Upstream is reset in the same domain.
//  - Error condition: B or R arriving with counter == 0 does not decrement. In simulation it raises an assertion.
// CONFIGURATION
//  `define AXI_EMIF_DRAIN_TIMEOUT_EN
//  - Defined:
//    - a cycle counter runs in DRAIN; if it reaches TIMEOUT_CYC, go to FROZEN anyway and set drain_timeout=1.
//    - counters are then cleared; late B/R responses are ignored.
//    - drain_timeout clears on entry to RUN.
//  - Undefined: no counter is built; drain_timeout is tied to 0; DRAIN waits indefinitely.
// TESTING
//  1. Idle, freeze_req=1 -> freeze_ack=1 two cycles later; all u_*ready=0 while frozen.
//  2. Freeze during a 4-beat write (AW accepted, 1 beat sent) -> 3 more W beats pass; freeze_ack only after the B handshake.
//  3. Back-pressure: d_arvalid=1 with d_arready=0 when freeze_req rises -> d_arvalid stays 1 until the handshake, then gates; ack follows the last R.
//  4. Push 64 ARs with no R returned -> 65th AR stalls (u_arready=0); one R with rlast -> AR accepted next cycle.
//  5. freeze_req pulsed 3 cycles with reads outstanding -> back to RUN, freeze_ack never rises, traffic resumes.
//  6. (Macro on, TIMEOUT_CYC=16) B withheld -> drain_timeout=1 and freeze_ack=1 at DRAIN+16; release -> both clear.

Source files
------------

// File: rtl/axi_emif_freeze_drain_ctrl.sv
// axi_emif_freeze_drain_ctrl
// Gates the AW/W/AR valid/ready handshakes between the user AXI-MM pipeline
// and the EMIF port. Payloads bypass this block. On freeze_req it stops new
// traffic without withdrawing a presented valid. It lets in-flight bursts and
// responses finish, then raises freeze_ack.
// Optional feature: define AXI_EMIF_DRAIN_TIMEOUT_EN to bound the drain by
// TIMEOUT_CYC cycles. On expiry the port freezes anyway and drain_timeout is set.
module axi_emif_freeze_drain_ctrl #(
  parameter int MAX_OUTSTANDING = 64,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1),
  parameter int TIMEOUT_CYC     = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic freeze_req,
  output logic freeze_ack,
  output logic drain_timeout,
  input  logic u_awvalid,
  output logic u_awready,
  input  logic u_wvalid,
  output logic u_wready,
  input  logic u_wlast,
  input  logic u_arvalid,
  output logic u_arready,
  output logic d_awvalid,
  input  logic d_awready,
  output logic d_wvalid,
  input  logic d_wready,
  output logic d_arvalid,
  input  logic d_arready,
  input  logic d_bvalid,
  input  logic d_bready,
  input  logic d_rvalid,
  input  logic d_rready,
  input  logic d_rlast
);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_FROZEN} state_t;

  localparam logic [CNT_W-1:0]        MAX_CNT = CNT_W'(MAX_OUTSTANDING);
  localparam logic signed [CNT_W:0]   W_MAX   = (CNT_W+1)'(MAX_OUTSTANDING);
  localparam logic signed [CNT_W:0]   W_MIN   = -W_MAX;

  state_t                  state;
  logic [CNT_W-1:0]        wr_out, rd_out;
  logic signed [CNT_W:0]   w_pend;
  logic                    aw_hold, w_hold, ar_hold, w_inburst;
  logic                    gate_aw, gate_w, gate_ar;
  logic                    aw_hs, w_hs, ar_hs, b_dec, r_dec;
  logic                    w_pend_le0, drain_done, timeout_hit, clear_cnt;

  // Gate selection: saturation in RUN, hold-aware gating in DRAIN, all shut when FROZEN
  always_comb begin
    gate_aw = 1'b0;
    gate_w  = 1'b0;
    gate_ar = 1'b0;
    case (state)
      ST_RUN: begin
        gate_aw = (wr_out == MAX_CNT);
        gate_ar = (rd_out == MAX_CNT);
      end
      ST_DRAIN: begin
        gate_aw = (wr_out == MAX_CNT) | ~aw_hold;
        gate_ar = (rd_out == MAX_CNT) | ~ar_hold;
        gate_w  = ~w_hold & ~w_inburst & w_pend_le0;
      end
      default: begin
        gate_aw = 1'b1;
        gate_w  = 1'b1;
        gate_ar = 1'b1;
      end
    endcase
  end

  assign d_awvalid = u_awvalid & ~gate_aw;
  assign u_awready = d_awready & ~gate_aw;
  assign d_wvalid  = u_wvalid  & ~gate_w;
  assign u_wready  = d_wready  & ~gate_w;
  assign d_arvalid = u_arvalid & ~gate_ar;
  assign u_arready = d_arready & ~gate_ar;

  assign aw_hs      = d_awvalid & d_awready;
  assign w_hs       = d_wvalid & d_wready;
  assign ar_hs      = d_arvalid & d_arready;
  // Responses with nothing outstanding are dropped rather than underflowing
  assign b_dec      = d_bvalid & d_bready & (wr_out != '0);
  assign r_dec      = d_rvalid & d_rready & d_rlast & (rd_out != '0);
  assign w_pend_le0 = w_pend[CNT_W] | (w_pend == '0);
  assign drain_done = (wr_out == '0) & (rd_out == '0) & (w_pend == '0) & ~w_inburst
                    & ~aw_hold & ~w_hold & ~ar_hold;

`ifdef AXI_EMIF_DRAIN_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt;
  logic            drain_timeout_reg;

  assign timeout_hit   = (state == ST_DRAIN) & freeze_req & ~drain_done
                       & (to_cnt == TO_W'(TIMEOUT_CYC - 1));
  assign clear_cnt     = timeout_hit;
  assign drain_timeout = drain_timeout_reg;

  // Drain cycle counter and sticky timeout flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt            <= '0;
      drain_timeout_reg <= 1'b0;
    end else begin
      to_cnt <= (state == ST_DRAIN && !timeout_hit) ? to_cnt + 1'b1 : '0;
      if (timeout_hit)
        drain_timeout_reg <= 1'b1;
      else if (!freeze_req)
        drain_timeout_reg <= 1'b0;
    end
  end
`else
  assign timeout_hit   = 1'b0;
  assign clear_cnt     = 1'b0;
  assign drain_timeout = 1'b0;
`endif

  // Freeze FSM with registered acknowledge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_RUN;
      freeze_ack <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          freeze_ack <= 1'b0;
          if (freeze_req) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          freeze_ack <= freeze_req & (drain_done | timeout_hit);
          if (!freeze_req)                    state <= ST_RUN;
          else if (drain_done || timeout_hit) state <= ST_FROZEN;
        end
        default: begin
          freeze_ack <= freeze_req;
          if (!freeze_req) state <= ST_RUN;
        end
      endcase
    end
  end

  // Outstanding-transaction counters and W burst tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_out    <= '0;
      rd_out    <= '0;
      w_pend    <= '0;
      w_inburst <= 1'b0;
    end else if (clear_cnt) begin
      wr_out    <= '0;
      rd_out    <= '0;
      w_pend    <= '0;
      w_inburst <= 1'b0;
    end else begin
      if (aw_hs && !b_dec)      wr_out <= wr_out + 1'b1;
      else if (!aw_hs && b_dec) wr_out <= wr_out - 1'b1;
      if (ar_hs && !r_dec)      rd_out <= rd_out + 1'b1;
      else if (!ar_hs && r_dec) rd_out <= rd_out - 1'b1;
      if (aw_hs && !(w_hs && u_wlast) && w_pend != W_MAX)
        w_pend <= w_pend + 1'sb1;
      else if (!aw_hs && w_hs && u_wlast && w_pend != W_MIN)
        w_pend <= w_pend - 1'sb1;
      if (w_hs) w_inburst <= ~u_wlast;
    end
  end

  // Hold flags: a valid presented downstream and not yet accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_hold <= 1'b0;
      w_hold  <= 1'b0;
      ar_hold <= 1'b0;
    end else begin
      aw_hold <= d_awvalid & ~d_awready;
      w_hold  <= d_wvalid & ~d_wready;
      ar_hold <= d_arvalid & ~d_arready;
    end
  end

`ifndef SYNTHESIS
  // A B or R with nothing outstanding is a protocol error, unless it is a late response after a timeout
  a_no_stray_b: assert property (@(posedge clk) disable iff (!rst_n)
    !(d_bvalid && d_bready && wr_out == '0 && !drain_timeout));
  a_no_stray_r: assert property (@(posedge clk) disable iff (!rst_n)
    !(d_rvalid && d_rready && d_rlast && rd_out == '0 && !drain_timeout));
`endif

endmodule

// File: tb/tb_axi_emif_freeze_drain_ctrl.sv
// Directed bench for axi_emif_freeze_drain_ctrl: pass-through vector table plus
// hand-written freeze/drain sequences. Timeout sequence only when
// AXI_EMIF_DRAIN_TIMEOUT_EN is defined.
module tb_axi_emif_freeze_drain_ctrl;

  logic clk = 1'b0;
  logic rst_n, freeze_req, freeze_ack, drain_timeout;
  logic u_awvalid, u_awready, u_wvalid, u_wready, u_wlast, u_arvalid, u_arready;
  logic d_awvalid, d_awready, d_wvalid, d_wready, d_arvalid, d_arready;
  logic d_bvalid, d_bready, d_rvalid, d_rready, d_rlast;

  int n_cmp = 0;
  int n_bad = 0;

  axi_emif_freeze_drain_ctrl #(.MAX_OUTSTANDING(64), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n), .freeze_req(freeze_req), .freeze_ack(freeze_ack),
    .drain_timeout(drain_timeout),
    .u_awvalid(u_awvalid), .u_awready(u_awready), .u_wvalid(u_wvalid),
    .u_wready(u_wready), .u_wlast(u_wlast), .u_arvalid(u_arvalid), .u_arready(u_arready),
    .d_awvalid(d_awvalid), .d_awready(d_awready), .d_wvalid(d_wvalid),
    .d_wready(d_wready), .d_arvalid(d_arvalid), .d_arready(d_arready),
    .d_bvalid(d_bvalid), .d_bready(d_bready), .d_rvalid(d_rvalid),
    .d_rready(d_rready), .d_rlast(d_rlast)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [5:0] in;   // {u_awvalid, d_awready, u_wvalid, d_wready, u_arvalid, d_arready}
    logic [5:0] exp;  // {d_awvalid, u_awready, d_wvalid, u_wready, d_arvalid, u_arready}
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else
      $display("ok   %s: %0h", name, act);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    {u_awvalid, d_awready, u_wvalid, d_wready, u_wlast, u_arvalid, d_arready} = '0;
    {d_bvalid, d_bready, d_rvalid, d_rready, d_rlast} = '0;
  endtask

  function automatic logic [5:0] outs();
    return {d_awvalid, u_awready, d_wvalid, u_wready, d_arvalid, u_arready};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"pt_all_zero",  6'b000000, 6'b000000};
    vecs[1] = '{"pt_aw_only",   6'b100000, 6'b100000};
    vecs[2] = '{"pt_awready",   6'b010000, 6'b010000};
    vecs[3] = '{"pt_w_hs",      6'b001100, 6'b001100};
    vecs[4] = '{"pt_ar_bp",     6'b000010, 6'b000010};
    vecs[5] = '{"pt_ar_hs",     6'b000011, 6'b000011};
    vecs[6] = '{"pt_mix",       6'b100110, 6'b100110};
    vecs[7] = '{"pt_all_one",   6'b111111, 6'b111111};

    idle_inputs();
    freeze_req = 1'b0;
    rst_n = 1'b0;
    tick(); tick();
    check("rst_ack", freeze_ack, 0);
    check("rst_timeout", drain_timeout, 0);
    rst_n = 1'b1;
    tick();

    // Pass-through table in RUN
    foreach (vecs[i]) begin
      {u_awvalid, d_awready, u_wvalid, d_wready, u_arvalid, d_arready} = vecs[i].in;
      #1;
      check(vecs[i].name, outs(), vecs[i].exp);
      tick();
    end
    idle_inputs();
    // Clear any counts left by the table with an asynchronous reset pulse
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    tick();

    // 1: idle freeze, ack two cycles later, everything blocked while frozen
    freeze_req = 1'b1;
    tick();
    check("t1_ack_drain", freeze_ack, 0);
    tick();
    check("t1_ack_frozen", freeze_ack, 1);
    {u_awvalid, d_awready, u_wvalid, d_wready, u_arvalid, d_arready} = 6'b111111;
    #1;
    check("t1_frozen_gated", outs(), 6'b000000);
    idle_inputs();
    // Asynchronous reset while frozen drops the ack immediately
    #1 rst_n = 1'b0;
    #1;
    check("t1_async_rst_ack", freeze_ack, 0);
    freeze_req = 1'b0;
    rst_n = 1'b1;
    tick();

    // 2: freeze in the middle of a 4-beat write
    u_awvalid = 1'b1; d_awready = 1'b1;
    tick();
    u_awvalid = 1'b0; d_awready = 1'b0;
    u_wvalid = 1'b1; d_wready = 1'b1; u_wlast = 1'b0;
    tick();
    freeze_req = 1'b1;
    tick();
    check("t2_beat3_pass", u_wready, 1);
    tick();
    u_wlast = 1'b1;
    #1;
    check("t2_beat4_pass", u_wready, 1);
    tick();
    u_wlast = 1'b0;
    #1;
    check("t2_new_w_gated", {d_wvalid, u_wready}, 2'b00);
    u_wvalid = 1'b0; d_wready = 1'b0;
    u_awvalid = 1'b1; d_awready = 1'b1;
    #1;
    check("t2_new_aw_gated", {d_awvalid, u_awready}, 2'b00);
    u_awvalid = 1'b0; d_awready = 1'b0;
    tick(); tick();
    check("t2_no_ack_before_b", freeze_ack, 0);
    d_bvalid = 1'b1; d_bready = 1'b1;
    tick();
    d_bvalid = 1'b0; d_bready = 1'b0;
    check("t2_ack_b_edge", freeze_ack, 0);
    tick();
    check("t2_ack_after_b", freeze_ack, 1);
    freeze_req = 1'b0;
    tick();
    check("t2_ack_release", freeze_ack, 0);

    // 3: AR back-pressured when freeze rises
    u_arvalid = 1'b1; d_arready = 1'b0;
    tick();
    freeze_req = 1'b1;
    tick();
    check("t3_ar_held_1", d_arvalid, 1);
    tick();
    check("t3_ar_held_2", d_arvalid, 1);
    d_arready = 1'b1;
    #1;
    check("t3_ar_hs", u_arready, 1);
    tick();
    d_arready = 1'b0;
    #1;
    check("t3_ar_gated", d_arvalid, 0);
    u_arvalid = 1'b0;
    tick();
    check("t3_no_ack_before_r", freeze_ack, 0);
    d_rvalid = 1'b1; d_rready = 1'b1; d_rlast = 1'b1;
    tick();
    idle_inputs();
    tick();
    check("t3_ack_after_r", freeze_ack, 1);
    freeze_req = 1'b0;
    tick();

    // 4: AR saturation at 64 outstanding
    u_arvalid = 1'b1; d_arready = 1'b1;
    for (int i = 0; i < 64; i++) tick();
    check("t4_ar65_stall", u_arready, 0);
    d_rvalid = 1'b1; d_rready = 1'b1; d_rlast = 1'b1;
    #1;
    check("t4_stall_during_r", u_arready, 0);
    tick();
    d_rvalid = 1'b0; d_rready = 1'b0; d_rlast = 1'b0;
    #1;
    check("t4_ar_after_r", u_arready, 1);
    tick();
    u_arvalid = 1'b0; d_arready = 1'b0;
    d_rvalid = 1'b1; d_rready = 1'b1; d_rlast = 1'b1;
    for (int i = 0; i < 64; i++) tick();
    idle_inputs();

    // 5: aborted freeze with reads outstanding
    u_arvalid = 1'b1; d_arready = 1'b1;
    tick(); tick();
    idle_inputs();
    freeze_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5_no_ack", freeze_ack, 0);
    end
    freeze_req = 1'b0;
    tick();
    check("t5_no_ack_after", freeze_ack, 0);
    u_arvalid = 1'b1; d_arready = 1'b1;
    #1;
    check("t5_traffic_resumes", {d_arvalid, u_arready}, 2'b11);
    tick();
    idle_inputs();
    d_rvalid = 1'b1; d_rready = 1'b1; d_rlast = 1'b1;
    tick(); tick(); tick();
    idle_inputs();
    // All three reads returned: a fresh freeze completes in two cycles
    freeze_req = 1'b1;
    tick(); tick();
    check("t5_clean_freeze", freeze_ack, 1);
    freeze_req = 1'b0;
    tick();

`ifdef AXI_EMIF_DRAIN_TIMEOUT_EN
    // 6: B withheld, drain ends by timeout
    u_awvalid = 1'b1; d_awready = 1'b1;
    u_wvalid = 1'b1; d_wready = 1'b1; u_wlast = 1'b1;
    tick();
    idle_inputs();
    freeze_req = 1'b1;
    tick();
    for (int i = 0; i < 15; i++) tick();
    check("t6_no_ack_before_to", {drain_timeout, freeze_ack}, 2'b00);
    tick();
    check("t6_timeout_ack", {drain_timeout, freeze_ack}, 2'b11);
    freeze_req = 1'b0;
    tick();
    check("t6_release", {drain_timeout, freeze_ack}, 2'b00);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
